// File: rtl/vault_controller.sv
// Outer vault door controller.
// Dual-control open (officer + manager PIN on one request), close refused
// while the inner safe is open, timed lockout after repeated bad entries.
// A free-running prescaler tick paces both the button debounce and the
// lockout timer, so one parameter scales all human-facing timing.
module vault_controller #(
    parameter int         TICK_WIDTH     = 20,
    parameter int         DEBOUNCE_TICKS = 2,
    parameter int         MAX_FAILS      = 3,
    parameter int         LOCKOUT_TICKS  = 64,
    parameter logic [3:0] OFFICER_PIN    = 4'b1010,
    parameter logic [3:0] MANAGER_PIN    = 4'b0101
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] OfficerPINRead,
    input  logic [3:0] ManagerPINRead,
    input  logic       OpenClosePush,
    input  logic       SafeStatus,
    output logic       VaultStatus,
    output logic       InvalidLED,
    output logic       LockoutLED,
    output logic [2:0] CurrentState
);

    typedef enum logic [2:0] {
        VAULT_CLOSED   = 3'b000,
        VALIDATE_OPEN  = 3'b001,
        VAULT_OPENED   = 3'b011,
        VALIDATE_CLOSE = 3'b111,
        LOCKOUT        = 3'b100
    } vaultState_t;

    localparam int DB_W   = $clog2(DEBOUNCE_TICKS + 1);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int LOCK_W = $clog2(LOCKOUT_TICKS);

    localparam logic [TICK_WIDTH-1:0] PRE_ONE   = TICK_WIDTH'(1);
    localparam logic [DB_W-1:0]       DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]       DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [FAIL_W-1:0]     FAIL_ONE  = FAIL_W'(1);
    localparam logic [FAIL_W-1:0]     FAIL_MAX  = FAIL_W'(MAX_FAILS);
    localparam logic [LOCK_W-1:0]     LOCK_ONE  = LOCK_W'(1);
    localparam logic [LOCK_W-1:0]     LOCK_LAST = LOCK_W'(LOCKOUT_TICKS - 1);

    logic [TICK_WIDTH-1:0] prescaler;
    logic                  tick;
    logic [1:0]            buttonSync;
    logic                  buttonDebounced;
    logic                  buttonDebouncedPrev;
    logic [DB_W-1:0]       debounceCount;
    logic                  pressPulse;
    logic                  releasePulse;

    vaultState_t           state;
    vaultState_t           stateNext;
    logic                  invalidFlag;
    logic                  invalidNext;
    logic                  lockoutFlag;
    logic                  vaultOpenFlag;
    logic [FAIL_W-1:0]     failCount;
    logic [FAIL_W-1:0]     failNext;
    logic [FAIL_W-1:0]     failIncr;
    logic [LOCK_W-1:0]     lockoutCount;
    logic [LOCK_W-1:0]     lockoutCountNext;
    logic                  pinsMatch;
    logic                  pinsCleared;

    // Free-running prescaler; tick fires for one cycle when it wraps.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRE_ONE;
        end
    end

    assign tick = &prescaler;

    // Two-flop synchroniser for the raw, asynchronous push button.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            buttonSync <= 2'b00;
        end else begin
            buttonSync <= {buttonSync[0], OpenClosePush};
        end
    end

    // Debounce: the synchronised level must disagree for DEBOUNCE_TICKS
    // consecutive ticks; any agreement in between restarts the count.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            buttonDebounced     <= 1'b0;
            buttonDebouncedPrev <= 1'b0;
            debounceCount       <= '0;
        end else begin
            buttonDebouncedPrev <= buttonDebounced;
            if (buttonSync[1] == buttonDebounced) begin
                debounceCount <= '0;
            end else if (tick) begin
                if (debounceCount == DB_LAST) begin
                    buttonDebounced <= buttonSync[1];
                    debounceCount   <= '0;
                end else begin
                    debounceCount <= debounceCount + DB_ONE;
                end
            end
        end
    end

    assign pressPulse   = buttonDebounced & ~buttonDebouncedPrev;
    assign releasePulse = ~buttonDebounced & buttonDebouncedPrev;

    // Next-state, fail-count and lockout-timer decisions for the door FSM.
    always_comb begin
        stateNext        = state;
        invalidNext      = invalidFlag;
        failNext         = failCount;
        lockoutCountNext = lockoutCount;
        pinsMatch        = (OfficerPINRead == OFFICER_PIN) && (ManagerPINRead == MANAGER_PIN);
        pinsCleared      = (OfficerPINRead == 4'b0000) && (ManagerPINRead == 4'b0000);
        if (failCount == FAIL_MAX) begin
            failIncr = failCount;
        end else begin
            failIncr = failCount + FAIL_ONE;
        end
        case (state)
            VAULT_CLOSED: begin
                if (pressPulse) begin
                    stateNext = VALIDATE_OPEN;
                end else begin
                    stateNext = VAULT_CLOSED;
                end
            end
            VALIDATE_OPEN: begin
                if (releasePulse) begin
                    if (pinsMatch) begin
                        stateNext   = VAULT_OPENED;
                        invalidNext = 1'b0;
                        failNext    = '0;
                    end else begin
                        invalidNext = 1'b1;
                        failNext    = failIncr;
                        if (failIncr == FAIL_MAX) begin
                            stateNext = LOCKOUT;
                        end else begin
                            stateNext = VAULT_CLOSED;
                        end
                    end
                end else begin
                    stateNext = VALIDATE_OPEN;
                end
            end
            VAULT_OPENED: begin
                if (pressPulse) begin
                    stateNext = VALIDATE_CLOSE;
                end else begin
                    stateNext = VAULT_OPENED;
                end
            end
            VALIDATE_CLOSE: begin
                if (releasePulse) begin
                    // Never shut the outer door on an open inner safe.
                    if (!SafeStatus && pinsCleared) begin
                        stateNext   = VAULT_CLOSED;
                        invalidNext = 1'b0;
                    end else begin
                        stateNext   = VAULT_OPENED;
                        invalidNext = 1'b1;
                    end
                end else begin
                    stateNext = VALIDATE_CLOSE;
                end
            end
            LOCKOUT: begin
                if (tick) begin
                    if (lockoutCount == LOCK_LAST) begin
                        stateNext        = VAULT_CLOSED;
                        invalidNext      = 1'b0;
                        failNext         = '0;
                        lockoutCountNext = '0;
                    end else begin
                        lockoutCountNext = lockoutCount + LOCK_ONE;
                    end
                end else begin
                    stateNext = LOCKOUT;
                end
            end
            default: begin
                stateNext        = VAULT_CLOSED;
                invalidNext      = 1'b0;
                failNext         = '0;
                lockoutCountNext = '0;
            end
        endcase
    end

    // State, counters and registered outputs, all derived from the next state.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state         <= VAULT_CLOSED;
            invalidFlag   <= 1'b0;
            lockoutFlag   <= 1'b0;
            vaultOpenFlag <= 1'b0;
            failCount     <= '0;
            lockoutCount  <= '0;
        end else begin
            state         <= stateNext;
            invalidFlag   <= invalidNext;
            lockoutFlag   <= (stateNext == LOCKOUT);
            vaultOpenFlag <= (stateNext == VAULT_OPENED) || (stateNext == VALIDATE_CLOSE);
            failCount     <= failNext;
            lockoutCount  <= lockoutCountNext;
        end
    end

    assign CurrentState = state;
    assign VaultStatus  = vaultOpenFlag;
    assign InvalidLED   = invalidFlag;
    assign LockoutLED   = lockoutFlag;

endmodule
